// File: rtl/pong_pkg.sv
// Shared constants and the state type for the pong scoring logic.
package pong_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } state_t;

  localparam int unsigned SCREEN_W           = 640;
  localparam int unsigned DEF_LEFT_GOAL      = 85;
  localparam int unsigned DEF_RIGHT_GOAL     = 555;
  localparam int unsigned DEF_WIN_SCORE      = 9;
  localparam int unsigned DEF_PAUSE_FRAMES   = 60;

endpackage

// File: rtl/edge_detect.sv
// Shift-register synchroniser with a rising-edge pulse taken off its last two taps.
module edge_detect #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic rise
);

  // sr[STAGES-1] is the settled level, sr[STAGES] its one-clk history
  logic [STAGES:0] sr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sr <= {(STAGES + 1){RESET_VAL}};
    else          sr <= {sr[STAGES-1:0], d};
  end

  assign rise = sr[STAGES-1] & ~sr[STAGES];

endmodule

// File: rtl/score_keeper.sv
// Pong score keeper: detects misses once per frame, tracks scores, paces serves.
module score_keeper
  import pong_pkg::*;
#(
  parameter int unsigned LEFT_GOAL    = DEF_LEFT_GOAL,
  parameter int unsigned RIGHT_GOAL   = DEF_RIGHT_GOAL,
  parameter int unsigned WIN_SCORE    = DEF_WIN_SCORE,
  parameter int unsigned PAUSE_FRAMES = DEF_PAUSE_FRAMES
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       vsync,
  input  logic [9:0] ball_x_pos,
  input  logic       start,
  output logic       serve,
  output logic       serve_dir,
  output logic [3:0] left_score,
  output logic [3:0] right_score,
  output logic       playing,
  output logic       game_over
);

  state_t     state;
  logic [7:0] pause_cnt;
  logic       tick;
  logic       start_evt;
  logic       left_miss;
  logic       right_miss;
  logic [3:0] left_inc;
  logic [3:0] right_inc;

  edge_detect #(.STAGES(1), .RESET_VAL(1'b1)) u_vsync_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (vsync),
    .rise    (tick)
  );

  edge_detect #(.STAGES(2), .RESET_VAL(1'b0)) u_start_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (start),
    .rise    (start_evt)
  );

  // Positions at or past the screen width are a wrapped underflow off the left edge
  always_comb begin
    left_miss  = (ball_x_pos <= 10'(LEFT_GOAL)) || (ball_x_pos >= 10'(SCREEN_W));
    right_miss = !left_miss && (ball_x_pos >= 10'(RIGHT_GOAL));
    left_inc   = left_score + 4'd1;
    right_inc  = right_score + 4'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      pause_cnt   <= '0;
      serve       <= 1'b0;
      serve_dir   <= 1'b1;
      left_score  <= '0;
      right_score <= '0;
      playing     <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      serve <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_evt) begin
            serve     <= 1'b1;
            serve_dir <= 1'b1;
            playing   <= 1'b1;
            state     <= PLAY;
          end
        end
        PLAY: begin
          if (tick && (left_miss || right_miss)) begin
            playing <= 1'b0;
            if (left_miss) begin
              right_score <= right_inc;
              serve_dir   <= 1'b0;
            end else begin
              left_score  <= left_inc;
              serve_dir   <= 1'b1;
            end
            if ((left_miss ? right_inc : left_inc) == 4'(WIN_SCORE)) begin
              game_over <= 1'b1;
              state     <= OVER;
            end else begin
              pause_cnt <= 8'(PAUSE_FRAMES);
              state     <= PAUSE;
            end
          end
        end
        PAUSE: begin
          if (tick) begin
            pause_cnt <= pause_cnt - 8'd1;
            if (pause_cnt == 8'd1) begin
              serve   <= 1'b1;
              playing <= 1'b1;
              state   <= PLAY;
            end
          end
        end
        OVER: begin
          if (start_evt) begin
            left_score  <= '0;
            right_score <= '0;
            serve       <= 1'b1;
            serve_dir   <= 1'b1;
            playing     <= 1'b1;
            game_over   <= 1'b0;
            state       <= PLAY;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
